// File: rtl/bus8_reg_bank_pkg.sv
// ----------------------------------------------------------------------------
// bus8_regs_pkg
// Shared definitions for the 8-bit bus register bank:
//   - register offsets decoded from i_Bus_Addr8[3:0]
//   - CTRL bit positions and the mask of CTRL bits that are actually stored
//   - value returned for reads of unmapped offsets
//   - the {valid, data} beat carried by the read-return pipeline
// ----------------------------------------------------------------------------
package bus8_regs_pkg;

    // Register offsets (i_Bus_Addr8[3:0])
    localparam logic [3:0] REG_ID      = 4'h0;
    localparam logic [3:0] REG_SCRATCH = 4'h1;
    localparam logic [3:0] REG_CTRL    = 4'h2;
    localparam logic [3:0] REG_STATUS  = 4'h3;
    localparam logic [3:0] REG_EVENT   = 4'h4;
    localparam logic [3:0] REG_IRQ_EN  = 4'h5;
    localparam logic [3:0] REG_CNT_LO  = 4'h6;
    localparam logic [3:0] REG_CNT_HI  = 4'h7;

    // CTRL bit positions
    localparam int unsigned CTRL_CNT_EN  = 0;
    localparam int unsigned CTRL_CNT_CLR = 1;

    // The clear bit is a strobe, never stored, so it always reads back 0
    localparam logic [7:0] CTRL_STORE_MASK = 8'hFD;

    // Returned for offsets 0x8..0xF
    localparam logic [7:0] UNMAPPED_RD_VALUE = 8'h00;

    // One read-return pipeline stage
    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } rd_beat_t;

endpackage : bus8_regs_pkg

// File: rtl/bus8_reg_bank_if.sv
// ----------------------------------------------------------------------------
// bus8_reg_bank_if
// 8-bit chip-select bus between the UART-to-bus bridge (master) and a bus
// target (slave).
//   i_Bus_CS       one-cycle access strobe
//   i_Bus_Wr_Rd_n  1 = write, 0 = read, qualified by CS
//   i_Bus_Addr8    byte address
//   i_Bus_Wr_Data  write data, qualified by CS & Wr_Rd_n
//   o_Bus_Rd_Data  read data, valid while o_Bus_Rd_DV = 1
//   o_Bus_Rd_DV    one-cycle read-data-valid pulse
// ----------------------------------------------------------------------------
interface bus8_reg_bank_if;

    logic        i_Bus_CS;
    logic        i_Bus_Wr_Rd_n;
    logic [15:0] i_Bus_Addr8;
    logic [7:0]  i_Bus_Wr_Data;
    logic [7:0]  o_Bus_Rd_Data;
    logic        o_Bus_Rd_DV;

    modport master (
        output i_Bus_CS,
        output i_Bus_Wr_Rd_n,
        output i_Bus_Addr8,
        output i_Bus_Wr_Data,
        input  o_Bus_Rd_Data,
        input  o_Bus_Rd_DV
    );

    modport slave (
        input  i_Bus_CS,
        input  i_Bus_Wr_Rd_n,
        input  i_Bus_Addr8,
        input  i_Bus_Wr_Data,
        output o_Bus_Rd_Data,
        output o_Bus_Rd_DV
    );

endinterface : bus8_reg_bank_if

// File: rtl/bus8_rd_pipe.sv
// ----------------------------------------------------------------------------
// bus8_rd_pipe
// DEPTH-stage shift register carrying {valid, data[7:0]} read returns.
// A push in cycle N appears on o_Valid/o_Data in cycle N+DEPTH.
// Data of a stage only loads when the incoming beat is valid, so o_Data
// holds the last returned value between valid pulses.
// Ports:
//   i_Bus_Clk    clock
//   i_Bus_Rst_L  asynchronous active-low reset; drops every in-flight beat
//   i_Push       insert a beat this cycle
//   i_Data       data of the inserted beat
//   o_Valid      one-cycle valid pulse at the pipe output
//   o_Data       data of the most recent valid beat
// ----------------------------------------------------------------------------
module bus8_rd_pipe
    import bus8_regs_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic       i_Bus_Clk,
    input  logic       i_Bus_Rst_L,
    input  logic       i_Push,
    input  logic [7:0] i_Data,
    output logic       o_Valid,
    output logic [7:0] o_Data
);

    rd_beat_t [DEPTH-1:0] stage;

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            stage <= '0;
        end else begin
            stage[0].valid <= i_Push;
            if (i_Push) begin
                stage[0].data <= i_Data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i].valid <= stage[i-1].valid;
                if (stage[i-1].valid) begin
                    stage[i].data <= stage[i-1].data;
                end
            end
        end
    end

    assign o_Valid = stage[DEPTH-1].valid;
    assign o_Data  = stage[DEPTH-1].data;

endmodule : bus8_rd_pipe

// File: rtl/bus8_reg_bank.sv
// ----------------------------------------------------------------------------
// bus8_reg_bank
// 8-bit bus target register bank behind the UART-to-bus bridge.
// Map (offset = i_Bus_Addr8[3:0]):
//   0x0 ID (RO)        0x1 SCRATCH (RW)     0x2 CTRL (RW, bit1 self-clears)
//   0x3 STATUS (RO)    0x4 EVENT (W1C)      0x5 IRQ_EN (RW)
//   0x6 CNT_LO (RO, latches CNT_HI snapshot) 0x7 CNT_HI snapshot (RO)
//   0x8..0xF unmapped: read 0x00 with DV, writes ignored
// Parameters:
//   RD_LATENCY  cycles from CS to o_Bus_Rd_DV (1..4)
//   ID_VALUE    constant at offset 0x0
//   CTRL_RESET  CTRL reset value (bit1 is masked off)
// Ports:
//   i_Bus_Clk    clock
//   i_Bus_Rst_L  asynchronous active-low reset
//   bus          slave side of the 8-bit bus
//   o_Ctrl       CTRL register contents
//   i_Status     live status, sampled on a STATUS read
//   i_Event      event inputs setting sticky EVENT bits
//   o_Irq        registered |(EVENT & IRQ_EN)
// ----------------------------------------------------------------------------
module bus8_reg_bank
    import bus8_regs_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  ID_VALUE   = 8'hA5,
    parameter logic [7:0]  CTRL_RESET = 8'h00
) (
    input  logic             i_Bus_Clk,
    input  logic             i_Bus_Rst_L,
    bus8_reg_bank_if.slave   bus,
    output logic [7:0]       o_Ctrl,
    input  logic [7:0]       i_Status,
    input  logic [7:0]       i_Event,
    output logic             o_Irq
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("bus8_reg_bank: RD_LATENCY must be in 1..4");
    end

    logic [3:0]  offset;
    logic        wr_stb;
    logic        rd_stb;
    logic [7:0]  event_clr;
    logic [7:0]  rd_mux;
    logic        unused_addr_hi;

    logic [7:0]  scratch_q;
    logic [7:0]  ctrl_q;
    logic        cnt_clr_q;
    logic [7:0]  event_q;
    logic [7:0]  irq_en_q;
    logic [15:0] cnt_q;
    logic [7:0]  cnt_hi_q;
    logic        irq_q;

    assign offset         = bus.i_Bus_Addr8[3:0];
    assign unused_addr_hi = ^bus.i_Bus_Addr8[15:4];
    assign wr_stb         = bus.i_Bus_CS &  bus.i_Bus_Wr_Rd_n;
    assign rd_stb         = bus.i_Bus_CS & ~bus.i_Bus_Wr_Rd_n;
    assign event_clr      = (wr_stb && offset == REG_EVENT) ? bus.i_Bus_Wr_Data : '0;

    // Read data is taken from register values present in the CS cycle
    always_comb begin
        rd_mux = UNMAPPED_RD_VALUE;
        case (offset)
            REG_ID:      rd_mux = ID_VALUE;
            REG_SCRATCH: rd_mux = scratch_q;
            REG_CTRL:    rd_mux = ctrl_q;
            REG_STATUS:  rd_mux = i_Status;
            REG_EVENT:   rd_mux = event_q;
            REG_IRQ_EN:  rd_mux = irq_en_q;
            REG_CNT_LO:  rd_mux = cnt_q[7:0];
            REG_CNT_HI:  rd_mux = cnt_hi_q;
            default:     rd_mux = UNMAPPED_RD_VALUE;
        endcase
    end

    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            scratch_q <= '0;
            ctrl_q    <= CTRL_RESET & CTRL_STORE_MASK;
            cnt_clr_q <= 1'b0;
            event_q   <= '0;
            irq_en_q  <= '0;
            cnt_q     <= '0;
            cnt_hi_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            cnt_clr_q <= 1'b0;

            if (wr_stb) begin
                case (offset)
                    REG_SCRATCH: scratch_q <= bus.i_Bus_Wr_Data;
                    REG_CTRL: begin
                        ctrl_q    <= bus.i_Bus_Wr_Data & CTRL_STORE_MASK;
                        cnt_clr_q <= bus.i_Bus_Wr_Data[CTRL_CNT_CLR];
                    end
                    REG_IRQ_EN:  irq_en_q <= bus.i_Bus_Wr_Data;
                    default: ;
                endcase
            end

            // Set term applied after the clear so a coincident event wins
            event_q <= (event_q & ~event_clr) | i_Event;

            // Clear strobe is registered: it acts on the edge after the write
            if (cnt_clr_q) begin
                cnt_q <= '0;
            end else if (ctrl_q[CTRL_CNT_EN]) begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (rd_stb && offset == REG_CNT_LO) begin
                cnt_hi_q <= cnt_q[15:8];
            end

            irq_q <= |(event_q & irq_en_q);
        end
    end

    bus8_rd_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_pipe (
        .i_Bus_Clk   (i_Bus_Clk),
        .i_Bus_Rst_L (i_Bus_Rst_L),
        .i_Push      (rd_stb),
        .i_Data      (rd_mux),
        .o_Valid     (bus.o_Bus_Rd_DV),
        .o_Data      (bus.o_Bus_Rd_Data)
    );

    assign o_Ctrl = ctrl_q;
    assign o_Irq  = irq_q;

endmodule : bus8_reg_bank

// File: tb/tb_bus8_reg_bank.sv
// ----------------------------------------------------------------------------
// tb_bus8_reg_bank
// Three register banks (RD_LATENCY 1, 2, 3) share the same stimulus. A
// register-level model predicts register contents, read returns and their
// arrival cycle; every cycle each bank's bus outputs, o_Ctrl and o_Irq are
// compared with the model. Directed sequences cover the documented cases,
// then a randomized phase exercises mixed traffic.
// ----------------------------------------------------------------------------
module tb_bus8_reg_bank;

    localparam logic [7:0] ID_V     = 8'hA5;
    localparam logic [7:0] CTRL_RST = 8'h5B;

    typedef struct {
        int         due;
        logic [7:0] d;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] status_in;
    logic [7:0] event_in;
    logic [7:0] ctrl1, ctrl2, ctrl3;
    logic       irq1, irq2, irq3;

    bus8_reg_bank_if bi1();
    bus8_reg_bank_if bi2();
    bus8_reg_bank_if bi3();

    always #5 clk = ~clk;

    bus8_reg_bank #(.RD_LATENCY(1), .ID_VALUE(ID_V), .CTRL_RESET(CTRL_RST)) u_dut1 (
        .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .bus(bi1.slave), .o_Ctrl(ctrl1),
        .i_Status(status_in), .i_Event(event_in), .o_Irq(irq1));
    bus8_reg_bank #(.RD_LATENCY(2), .ID_VALUE(ID_V), .CTRL_RESET(CTRL_RST)) u_dut2 (
        .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .bus(bi2.slave), .o_Ctrl(ctrl2),
        .i_Status(status_in), .i_Event(event_in), .o_Irq(irq2));
    bus8_reg_bank #(.RD_LATENCY(3), .ID_VALUE(ID_V), .CTRL_RESET(CTRL_RST)) u_dut3 (
        .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .bus(bi3.slave), .o_Ctrl(ctrl3),
        .i_Status(status_in), .i_Event(event_in), .o_Irq(irq3));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat [3] = '{1, 2, 3};

    rd_t        exp_q [3][$];
    logic [7:0] last_d [3];

    // Reference register state (values seen during the current cycle)
    logic [7:0]  m_scratch, m_ctrl, m_event, m_irq_en, m_snap;
    logic        m_clr_due, m_irq;
    logic [15:0] m_cnt;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_scratch = 8'h00;
        m_ctrl    = CTRL_RST & 8'hFD;
        m_event   = 8'h00;
        m_irq_en  = 8'h00;
        m_snap    = 8'h00;
        m_clr_due = 1'b0;
        m_irq     = 1'b0;
        m_cnt     = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].delete();
            last_d[k] = 8'h00;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] off, input logic [7:0] st);
        case (off)
            4'h0:    return ID_V;
            4'h1:    return m_scratch;
            4'h2:    return m_ctrl;
            4'h3:    return st;
            4'h4:    return m_event;
            4'h5:    return m_irq_en;
            4'h6:    return m_cnt[7:0];
            4'h7:    return m_snap;
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model across one clock edge, from the rules of the map
    task automatic model_edge(input logic cs, input logic wr, input logic [3:0] off,
                              input logic [7:0] wd, input logic [7:0] ev);
        logic        is_wr;
        logic [7:0]  n_event;
        logic [15:0] n_cnt;
        is_wr   = cs && wr;
        n_event = m_event | ev;
        if (is_wr && off == 4'h4) n_event = (m_event & ~wd) | ev;
        if (m_clr_due)     n_cnt = 16'h0000;
        else if (m_ctrl[0]) n_cnt = m_cnt + 16'd1;
        else               n_cnt = m_cnt;
        m_irq     = |(m_event & m_irq_en);
        m_clr_due = is_wr && off == 4'h2 && wd[1];
        if (is_wr && off == 4'h1) m_scratch = wd;
        if (is_wr && off == 4'h2) m_ctrl    = wd & 8'hFD;
        if (is_wr && off == 4'h5) m_irq_en  = wd;
        if (cs && !wr && off == 4'h6) m_snap = m_cnt[15:8];
        m_event = n_event;
        m_cnt   = n_cnt;
    endtask

    task automatic check_outputs();
        logic       dv [3];
        logic [7:0] dd [3];
        logic [7:0] cc [3];
        logic       qq [3];
        dv[0] = bi1.o_Bus_Rd_DV; dd[0] = bi1.o_Bus_Rd_Data; cc[0] = ctrl1; qq[0] = irq1;
        dv[1] = bi2.o_Bus_Rd_DV; dd[1] = bi2.o_Bus_Rd_Data; cc[1] = ctrl2; qq[1] = irq2;
        dv[2] = bi3.o_Bus_Rd_DV; dd[2] = bi3.o_Bus_Rd_Data; cc[2] = ctrl3; qq[2] = irq3;
        for (int k = 0; k < 3; k++) begin
            logic       e_dv;
            logic [7:0] e_d;
            e_dv = 1'b0;
            e_d  = last_d[k];
            if (exp_q[k].size() != 0 && exp_q[k][0].due == cyc) begin
                e_dv      = 1'b1;
                e_d       = exp_q[k][0].d;
                last_d[k] = e_d;
                void'(exp_q[k].pop_front());
            end
            check_val($sformatf("rd_dv_L%0d", lat[k]),   {15'd0, dv[k]}, {15'd0, e_dv});
            check_val($sformatf("rd_data_L%0d", lat[k]), {8'd0, dd[k]},  {8'd0, e_d});
            check_val($sformatf("ctrl_L%0d", lat[k]),    {8'd0, cc[k]},  {8'd0, m_ctrl});
            check_val($sformatf("irq_L%0d", lat[k]),     {15'd0, qq[k]}, {15'd0, m_irq});
        end
    endtask

    task automatic drive(input logic cs, input logic wr, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] st, input logic [7:0] ev);
        bi1.i_Bus_CS = cs; bi1.i_Bus_Wr_Rd_n = wr; bi1.i_Bus_Addr8 = addr; bi1.i_Bus_Wr_Data = wd;
        bi2.i_Bus_CS = cs; bi2.i_Bus_Wr_Rd_n = wr; bi2.i_Bus_Addr8 = addr; bi2.i_Bus_Wr_Data = wd;
        bi3.i_Bus_CS = cs; bi3.i_Bus_Wr_Rd_n = wr; bi3.i_Bus_Addr8 = addr; bi3.i_Bus_Wr_Data = wd;
        status_in = st;
        event_in  = ev;
    endtask

    // One bus cycle: drive after the falling edge, model the rising edge,
    // check outputs at the next falling edge.
    task automatic step(input logic cs, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] st, input logic [7:0] ev);
        drive(cs, wr, addr, wd, st, ev);
        if (cs && !wr && rst_n) begin
            for (int k = 0; k < 3; k++)
                exp_q[k].push_back('{due: cyc + lat[k], d: model_read(addr[3:0], st)});
        end
        @(posedge clk);
        if (rst_n) model_edge(cs, wr, addr[3:0], wd, ev);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] wd);
        step(1'b1, 1'b1, addr, wd, 8'h00, 8'h00);
    endtask

    // Latency-1 bank returns in the cycle right after the CS cycle
    task automatic read_expect(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        step(1'b1, 1'b0, addr, 8'h00, 8'h00, 8'h00);
        check_val(tag, {7'd0, bi1.o_Bus_Rd_DV, bi1.o_Bus_Rd_Data}, {8'h01, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_val("reset_ctrl", {8'd0, ctrl1}, 16'h0059);
        rst_n = 1'b1;

        // ID and unmapped reads
        read_expect("rd_event_after_reset", 16'h0014, 8'h00);
        read_expect("rd_id",                16'h0000, 8'hA5);
        read_expect("rd_unmapped",          16'h0009, 8'h00);

        // SCRATCH and CTRL
        bus_write(16'h0001, 8'h3C);
        read_expect("rd_scratch", 16'h0001, 8'h3C);
        bus_write(16'h0002, 8'hF3);
        check_val("o_ctrl_f3", {8'd0, ctrl1}, 16'h00F1);
        read_expect("rd_ctrl", 16'h0002, 8'hF1);
        bus_write(16'h0000, 8'h77);
        read_expect("rd_id_after_write", 16'h0000, 8'hA5);

        // Events and interrupt
        bus_write(16'h0005, 8'h04);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h05);
        idle(1);
        check_val("irq_set", {15'd0, irq1}, 16'h0001);
        read_expect("rd_event", 16'h0004, 8'h05);
        bus_write(16'h0004, 8'h04);
        idle(1);
        check_val("irq_clr", {15'd0, irq1}, 16'h0000);
        read_expect("rd_event_w1c", 16'h0004, 8'h01);
        bus_write(16'h0004, 8'h01);
        read_expect("rd_event_cleared", 16'h0004, 8'h00);
        step(1'b1, 1'b1, 16'h0004, 8'h01, 8'h00, 8'h01);
        read_expect("rd_event_set_wins", 16'h0004, 8'h01);

        // Counter wrap and CNT_HI snapshot
        bus_write(16'h0002, 8'h03);
        idle(65541);
        bus_write(16'h0002, 8'h00);
        read_expect("rd_cnt_lo", 16'h0006, 8'h05);
        read_expect("rd_cnt_hi", 16'h0007, 8'h00);
        bus_write(16'h0002, 8'h01);
        idle(300);
        read_expect("rd_cnt_hi_held", 16'h0007, 8'h00);
        bus_write(16'h0002, 8'h00);

        // Pipelined reads, latency-3 bank
        step(1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 16'h0001, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 16'h0003, 8'h00, 8'h5A, 8'h00);
        check_val("pipe_beat0", {7'd0, bi3.o_Bus_Rd_DV, bi3.o_Bus_Rd_Data}, 16'h01A5);
        idle(1);
        check_val("pipe_beat1", {7'd0, bi3.o_Bus_Rd_DV, bi3.o_Bus_Rd_Data}, 16'h013C);
        idle(1);
        check_val("pipe_beat2", {7'd0, bi3.o_Bus_Rd_DV, bi3.o_Bus_Rd_Data}, 16'h015A);
        idle(1);
        check_val("pipe_after", {7'd0, bi3.o_Bus_Rd_DV, bi3.o_Bus_Rd_Data}, 16'h005A);

        // Reset one cycle after a read CS: latency-2 return must be dropped
        step(1'b1, 1'b0, 16'h0001, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_val("rst_mid_data2", {7'd0, bi2.o_Bus_Rd_DV, bi2.o_Bus_Rd_Data}, 16'h0000);
        idle(2);
        check_val("rst_mid_nodv2", {15'd0, bi2.o_Bus_Rd_DV}, 16'h0000);
        rst_n = 1'b1;
        idle(3);

        // Randomized mixed traffic
        for (int i = 0; i < 3000; i++) begin
            logic        cs, wr;
            logic [15:0] addr;
            logic [7:0]  wd, st, ev;
            cs   = ($urandom % 3) != 0;
            wr   = $urandom % 2;
            addr = 16'($urandom);
            wd   = 8'($urandom);
            st   = 8'($urandom);
            ev   = (($urandom % 4) == 0) ? 8'($urandom) : 8'h00;
            step(cs, wr, addr, wd, st, ev);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_bus8_reg_bank
